// File: rtl/burst_accumulator.sv
// burst_accumulator: sums BURST input beats into a SIZE-bit result with a sticky carry flag.
// Define BURST_ACCUMULATOR_SATURATE_EN to saturate on carry instead of wrapping.
module burst_accumulator #(
  parameter int SIZE  = 4,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_sum,
  output logic            out_ovf
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t          r_state;
  state_t          w_next;
  logic [SIZE-1:0] r_acc;
  logic            r_ovf;
  logic [7:0]      r_cnt;
  logic            w_accept;
  logic            w_take;
  logic            w_last;
  logic [SIZE:0]   w_sum;
  logic [SIZE-1:0] w_acc_nxt;
  assign w_accept = (r_state == ACC) && in_valid;
  assign w_take   = (r_state == HOLD) && out_ready;
  assign w_last   = r_cnt == 8'(BURST - 1);
  assign w_sum    = {1'b0, r_acc} + {1'b0, in_data};
`ifdef BURST_ACCUMULATOR_SATURATE_EN
  assign w_acc_nxt = (w_sum[SIZE] || r_ovf) ? '1 : w_sum[SIZE-1:0];
`else
  assign w_acc_nxt = w_sum[SIZE-1:0];
`endif
  // State register; clear forces ACC and drops any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= clear ? ACC : w_next;
  end
  // Next state: ACC->HOLD on the last beat of a burst, HOLD->ACC when the result is taken
  always_comb begin
    w_next = (r_state == ACC) ? ((w_accept && w_last) ? HOLD : ACC)
                              : (out_ready ? ACC : HOLD);
  end
  // Outputs decode straight from registers, no combinational input-to-output paths
  always_comb begin
    in_ready  = r_state == ACC;
    out_valid = r_state == HOLD;
    out_sum   = r_acc;
    out_ovf   = r_ovf;
  end
  // Accumulator, sticky carry and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_ovf <= r_ovf | w_sum[SIZE];
      r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
    end else if (w_take) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_burst_accumulator.sv
// tb_burst_accumulator: scoreboard bench for burst_accumulator with a sum-of-beats reference model.
module tb_burst_accumulator;
  localparam int SIZE  = 4;
  localparam int BURST = 4;
  typedef struct {
    logic [SIZE-1:0] sum;
    logic            ovf;
  } res_t;
  logic            clk = 0;
  logic            rst_n = 0;
  logic            clear = 0;
  logic            in_valid = 0;
  logic            in_ready;
  logic [SIZE-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1;
  logic [SIZE-1:0] out_sum;
  logic            out_ovf;
  int   tests = 0;
  int   fails = 0;
  int   beats[$];
  res_t exp_q[$];
  res_t cur;
  bit   held = 0;
  bit   chk_lat = 0;
  burst_accumulator #(.SIZE(SIZE), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  // Expected result from the plain sum of a burst's beats
  function automatic res_t model(input int total);
    res_t r;
    r.ovf = total >= (1 << SIZE);
`ifdef BURST_ACCUMULATOR_SATURATE_EN
    r.sum = r.ovf ? '1 : SIZE'(total);
`else
    r.sum = SIZE'(total % (1 << SIZE));
`endif
    return r;
  endfunction
  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask
  // Input-side monitor: collects accepted beats and pushes the expected burst result
  always @(negedge clk) if (rst_n) begin
    if (chk_lat) begin
      check("latency_out_valid", int'(out_valid), 1);
      chk_lat = 0;
    end
    if (clear) beats.delete();
    else if (in_valid && in_ready) begin
      beats.push_back(int'(in_data));
      if (beats.size() == BURST) begin
        int t;
        t = 0;
        foreach (beats[k]) t += beats[k];
        exp_q.push_back(model(t));
        beats.delete();
        chk_lat = 1;
      end
    end
  end
  // Output-side monitor: pops on each new result, checks it stays stable while held
  always @(negedge clk) if (rst_n && out_valid) begin
    check("hold_in_ready", int'(in_ready), 0);
    if (!held) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: out_sum=%0d with no expected result", out_sum);
      end else begin
        cur = exp_q.pop_front();
        held = 1;
      end
    end
    if (held) begin
      check("out_sum", int'(out_sum), int'(cur.sum));
      check("out_ovf", int'(out_ovf), int'(cur.ovf));
    end
    if (clear || out_ready) held = 0;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int d, input bit rnd);
    in_valid = 1;
    in_data  = SIZE'(d);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i > 60) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        break;
      end
      cyc();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    cyc();
    in_valid = 0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic do_clear();
    clear = 1;
    cyc();
    clear = 0;
  endtask
  task automatic drain();
    out_ready = 1;
    repeat (3) cyc();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    cyc();
    rst_n = 1;
    foreach (beats[k]) beats[k] = 0;
    for (int b = 1; b <= 4; b++) send(b, 0);
    drain();
    send(8, 0); send(8, 0); send(1, 0); send(1, 0);
    drain();
    out_ready = 0;
    for (int b = 0; b < 4; b++) send(5, 0);
    in_valid = 1;
    in_data  = 7;
    repeat (5) begin
      check("hold_wait_valid", int'(out_valid), 1);
      cyc();
    end
    in_valid  = 0;
    out_ready = 1;
    cyc();
    check("taken_valid", int'(out_valid), 0);
    for (int b = 0; b < 4; b++) send(1, 0);
    drain();
    send(3, 0); send(3, 0);
    check("running_sum", int'(out_sum), 6);
    do_clear();
    check("clear_sum", int'(out_sum), 0);
    for (int b = 0; b < 4; b++) send(1, 0);
    drain();
    out_ready = 0;
    for (int b = 1; b <= 4; b++) send(b, 0);
    check("hold_before_clear", int'(out_valid), 1);
    do_clear();
    check("clear_drop_valid", int'(out_valid), 0);
    out_ready = 1;
    out_ready = 0;
    for (int b = 1; b <= 4; b++) send(b, 0);
    check("hold_sum_10", int'(out_sum), 10);
    #1 rst_n = 0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_sum", int'(out_sum), 0);
    check("async_rst_ready", int'(in_ready), 1);
    beats.delete();
    exp_q.delete();
    held = 0;
    chk_lat = 0;
    out_ready = 1;
    cyc();
    rst_n = 1;
    for (int b = 0; b < 4; b++) send(2, 0);
    drain();
    for (int b = 1; b <= 4; b++) begin
      send(b, 0);
      cyc();
    end
    drain();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 39) == 0) do_clear();
      send(int'($urandom_range(0, (1 << SIZE) - 1)), 1);
      repeat ($urandom_range(0, 2)) begin
        cyc();
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 0);
    check("no_result_held", int'(held), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
